// File: rtl/specdrum_pkg.sv
// specdrum_pkg: shared constants for the Specdrum playback controller.
//   PORT_DATA / PORT_STATUS : I/O addresses (low byte) of the data and status ports
//   DAC_MID                 : midscale DAC code, i.e. silence
//   ST_*                    : bit positions inside the status byte
package specdrum_pkg;

  localparam logic [7:0] PORT_DATA   = 8'hDF;
  localparam logic [7:0] PORT_STATUS = 8'hDE;
  localparam logic [7:0] DAC_MID     = 8'h80;

  localparam int ST_OVERRUN   = 7;
  localparam int ST_UNDERRUN  = 6;
  localparam int ST_FULL      = 5;
  localparam int ST_EMPTY     = 4;
  localparam int ST_LEVEL_LSB = 0;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO.
//   clock, reset : clock and synchronous active-high reset (control state only)
//   push, din    : enqueue request and data; accepted when not full, or when
//                  full and a pop is accepted in the same clock
//   pop, dout    : dequeue request; dout is registered on an accepted pop and
//                  holds otherwise. A pop on an empty FIFO is ignored.
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the same clock frees a slot.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage and output register carry data only; no reset needed. When full
  // with push and pop together, wr_ptr == rd_ptr and the read takes the old
  // entry before it is overwritten.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
    if (pop_ok)  dout        <= mem[rd_ptr];
  end

endmodule

// File: rtl/specdrum_player.sv
// specdrum_player: buffered sample playback for the 8-bit Specdrum DAC.
// CPU OUTs to port 0xDF are queued in a FIFO and released to the DAC once
// every DIVIDER clock enables.
//   clock, reset : clock and synchronous active-high reset
//   ce           : CPU clock enable; bus sampling and the divider advance on it
//   iorq, wr, rd : Z80 bus strobes, active low
//   a, d         : I/O address low byte and CPU data bus
//   q, qe        : status byte and its drive enable for the CPU data mux
//   dac          : sample presented to the mixer
// Build option: define SPECDRUM_STATUS_EN to decode the status port 0xDE.
// Without it q/qe are tied off and the sticky flags clear only on reset.
module specdrum_player
  import specdrum_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DIVIDER = 437
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       iorq,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] a,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       qe,
  output logic [7:0] dac
);

  localparam int CW = $clog2(DEPTH+1);

  logic          ws;
  logic          ws_d;
  logic          push;
  logic [15:0]   div_cnt;
  logic          tick;
  logic [7:0]    fifo_dout;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          started;
  logic          overrun;
  logic          underrun;
  logic          ov_set;
  logic          un_set;
  logic          clr;
  logic [8:0]    count_w;
  logic [3:0]    level;
  logic [7:0]    st;

  // Write decode and edge detect: one push per OUT however long it is held.
  assign ws   = !iorq && !wr && (a == PORT_DATA);
  assign push = ce && ws && !ws_d;

  // During reset ws_d follows the bus, so an OUT still held when reset
  // releases already looks "seen" and does not push; an idle bus gives 0.
  always_ff @(posedge clock) begin
    if (reset)   ws_d <= ws;
    else if (ce) ws_d <= ws;
  end

  // Sample-rate divider, free running, never restarted by writes.
  assign tick = ce && (div_cnt == 16'(DIVIDER-1));

  always_ff @(posedge clock) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else if (ce)   div_cnt <= div_cnt + 16'd1;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (tick),
    .din   (d),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // The FIFO output register is not reset; until the first real pop the DAC
  // shows midscale instead.
  always_ff @(posedge clock) begin
    if (reset)              started <= 1'b0;
    else if (tick && !empty) started <= 1'b1;
  end

  assign dac = started ? fifo_dout : DAC_MID;

  // Sticky flags. A pop on full frees a slot, so that push is not an overrun.
  // A set event in the same clock as the clear wins.
  assign ov_set = push && full && !tick;
  assign un_set = tick && empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= (overrun  && !clr) || ov_set;
      underrun <= (underrun && !clr) || un_set;
    end
  end

  // Status byte; level saturates at 15 for deep FIFOs.
  assign count_w = 9'(count);
  assign level   = (count_w > 9'd15) ? 4'hF : count_w[3:0];

  always_comb begin
    st                      = '0;
    st[ST_OVERRUN]          = overrun;
    st[ST_UNDERRUN]         = underrun;
    st[ST_FULL]             = full;
    st[ST_EMPTY]            = empty;
    st[ST_LEVEL_LSB +: 4]   = level;
  end

`ifdef SPECDRUM_STATUS_EN
  logic rs;
  logic rs_d;

  assign rs  = !iorq && !rd && (a == PORT_STATUS);
  // Flags clear as the read ends, after the CPU has taken the old value.
  assign clr = ce && !rs && rs_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      rs_d <= 1'b0;
      qe   <= 1'b0;
      q    <= 8'h00;
    end else if (ce) begin
      rs_d <= rs;
      qe   <= rs;
      q    <= rs ? st : 8'h00;
    end
  end
`else
  logic unused_status;

  assign clr = 1'b0;
  assign q   = 8'h00;
  assign qe  = 1'b0;
  assign unused_status = &{1'b0, rd, st, PORT_STATUS};
`endif

endmodule

// File: tb/tb_specdrum_player.sv
module tb_specdrum_player;

  localparam int DEPTH = 16;
  localparam int DIV   = 40;

  logic       clock;
  logic       reset;
  logic       ce;
  logic       iorq;
  logic       wr;
  logic       rd;
  logic [7:0] a;
  logic [7:0] d;
  logic [7:0] q;
  logic       qe;
  logic [7:0] dac;

  int checks;
  int errors;
  int ce_n;

  specdrum_player #(
    .DEPTH   (DEPTH),
    .DIVIDER (DIV)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .iorq  (iorq),
    .wr    (wr),
    .rd    (rd),
    .a     (a),
    .d     (d),
    .q     (q),
    .qe    (qe),
    .dac   (dac)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       wr_act;
    logic [7:0] data;
    int         nce;
    logic [7:0] exp_dac;
    int         exp_cnt;
    logic       exp_under;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    iorq = 1'b1; wr = 1'b1; rd = 1'b1; a = 8'h00; d = 8'h00;
  endtask

  task automatic bus_out(input logic [7:0] v);
    iorq = 1'b0; wr = 1'b0; rd = 1'b1; a = 8'hDF; d = v;
  endtask

  task automatic bus_in();
    iorq = 1'b0; wr = 1'b1; rd = 1'b0; a = 8'hDE; d = 8'h00;
  endtask

  // Each ce lasts one clock and is followed by one clock without ce.
  task automatic run_ce(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock) ce = 1'b1;
      @(negedge clock) ce = 1'b0;
      ce_n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; ce = 1'b0; bus_idle();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ce_n = 0;
  endtask

  task automatic out_byte(input logic [7:0] v);
    bus_out(v); run_ce(1);
    bus_idle(); run_ce(1);
  endtask

  initial begin
    checks = 0; errors = 0; ce_n = 0;
    reset = 1'b1; ce = 1'b0; bus_idle();

    // Three writes held 4 ce each; ticks at ce 40, 80, 120; empty tick at 160.
    tbl[0]  = '{1'b1, 8'h10, 1,  8'h80, 1, 1'b0};
    tbl[1]  = '{1'b1, 8'h10, 3,  8'h80, 1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1,  8'h80, 1, 1'b0};
    tbl[3]  = '{1'b1, 8'h20, 4,  8'h80, 2, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1,  8'h80, 2, 1'b0};
    tbl[5]  = '{1'b1, 8'h30, 4,  8'h80, 3, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1,  8'h80, 3, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 24, 8'h80, 3, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1,  8'h10, 2, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 39, 8'h10, 2, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1,  8'h20, 1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 40, 8'h30, 0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 40, 8'h30, 0, 1'b1};

    // Reset state
    do_reset();
    chk("rst dac", 32'(dac), 32'h80);
    chk("rst count", 32'(dut.count), 0);
    chk("rst qe", 32'(qe), 0);
    chk("rst q", 32'(q), 0);
    chk("rst overrun", 32'(dut.overrun), 0);
    chk("rst underrun", 32'(dut.underrun), 0);

    // Idle 3*DIV ce: underrun, DAC stays at midscale
    run_ce(3*DIV);
    chk("idle dac", 32'(dac), 32'h80);
    chk("idle underrun", 32'(dut.underrun), 1);
    bus_in(); run_ce(1);
`ifdef SPECDRUM_STATUS_EN
    chk("idle qe", 32'(qe), 1);
    chk("idle q", 32'(q), 32'h50);
`else
    chk("idle qe", 32'(qe), 0);
    chk("idle q", 32'(q), 0);
`endif
    bus_idle(); run_ce(1);

    // Table-driven playback sequence
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr_act) bus_out(tbl[i].data);
      else bus_idle();
      run_ce(tbl[i].nce);
      chk($sformatf("vec%0d dac", i), 32'(dac), 32'(tbl[i].exp_dac));
      chk($sformatf("vec%0d count", i), 32'(dut.count), 32'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d underrun", i), 32'(dut.underrun), 32'(tbl[i].exp_under));
    end

    // 17 OUTs into 16 entries, no tick yet; then drain
    do_reset();
    for (int i = 1; i <= 17; i++) out_byte(8'(i));
    chk("ovf count", 32'(dut.count), 16);
    chk("ovf full", 32'(dut.full), 1);
    chk("ovf overrun", 32'(dut.overrun), 1);
    for (int k = 1; k <= 16; k++) begin
      bus_idle(); run_ce(DIV*k - ce_n);
      chk($sformatf("drain%0d dac", k), 32'(dac), 32'(k));
    end
    run_ce(DIV);
    chk("ovf tail dac", 32'(dac), 32'h10);
    chk("ovf tail underrun", 32'(dut.underrun), 1);
    chk("ovf tail count", 32'(dut.count), 0);

    // Full FIFO, push coinciding with tick
    do_reset();
    for (int i = 0; i < 16; i++) out_byte(8'hA0 + 8'(i));
    chk("fp count pre", 32'(dut.count), 16);
    run_ce(DIV - 1 - ce_n);
    bus_out(8'hEE); run_ce(1);
    chk("fp count", 32'(dut.count), 16);
    chk("fp dac", 32'(dac), 32'hA0);
    chk("fp overrun", 32'(dut.overrun), 0);
    chk("fp full", 32'(dut.full), 1);
    bus_idle(); run_ce(1);
    for (int k = 1; k <= 16; k++) begin
      run_ce(DIV*(k+1) - ce_n);
      chk($sformatf("fp drain%0d dac", k), 32'(dac), (k < 16) ? 32'(8'hA0 + 8'(k)) : 32'hEE);
    end

    // Status reads after overrun
    do_reset();
    for (int i = 1; i <= 17; i++) out_byte(8'(i));
    bus_in(); run_ce(1);
`ifdef SPECDRUM_STATUS_EN
    chk("rd1 qe", 32'(qe), 1);
    chk("rd1 q", 32'(q), 32'hAF);
`else
    chk("rd1 qe", 32'(qe), 0);
    chk("rd1 q", 32'(q), 0);
`endif
    bus_idle(); run_ce(1);
    chk("rd1 release qe", 32'(qe), 0);
    bus_in(); run_ce(1);
`ifdef SPECDRUM_STATUS_EN
    chk("rd2 qe", 32'(qe), 1);
    chk("rd2 q", 32'(q), 32'h2F);
`else
    chk("rd2 qe", 32'(qe), 0);
    chk("rd2 q", 32'(q), 0);
`endif
    bus_idle(); run_ce(1);
`ifdef SPECDRUM_STATUS_EN
    chk("rd2 overrun", 32'(dut.overrun), 0);
`else
    chk("rd2 overrun", 32'(dut.overrun), 1);
`endif

    // Reset mid-playback with an OUT held across reset release
    do_reset();
    for (int i = 0; i < 9; i++) out_byte(8'h60 + 8'(i));
    run_ce(DIV - ce_n);
    chk("mr count pre", 32'(dut.count), 8);
    chk("mr dac pre", 32'(dac), 32'h60);
    bus_out(8'h77);
    reset = 1'b1;
    @(negedge clock);
    chk("mr count", 32'(dut.count), 0);
    chk("mr dac", 32'(dac), 32'h80);
    @(negedge clock);
    reset = 1'b0;
    ce_n = 0;
    run_ce(3);
    chk("mr held count", 32'(dut.count), 0);
    bus_idle(); run_ce(1);
    chk("mr idle count", 32'(dut.count), 0);
    bus_out(8'h55); run_ce(1);
    chk("mr new push count", 32'(dut.count), 1);
    bus_idle(); run_ce(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
